// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone master arbiter.
//
// Contents:
//   arb_state_t : arbiter FSM state (IDLE, ISSUE, RESP) and its encoding
//   TMO_CNT_W   : width of the slave-response timeout counter
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } arb_state_t;

  localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/wb_master_arbiter_if.sv
// Bundle of the requester-side and shared-bus Wishbone signals of the arbiter.
//
// Requester side (one slice per master, slice i at the i-th lowest bits):
//   wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i : requests
//   wbs_dat_o, wbs_ack_o, wbs_err_o                               : responses
// Shared bus side:
//   wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o : cycle out
//   wbm_dat_i, wbm_ack_i, wbm_err_i                                : slave reply
//
// Modports:
//   master : the arbiter itself (it is the master on the shared bus)
//   slave  : the surroundings (requesting masters plus the shared slave)
interface wb_master_arbiter_if #(
  parameter int NUM_MASTERS    = 2,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 32
);

  logic [NUM_MASTERS-1:0]                wbs_cyc_i;
  logic [NUM_MASTERS-1:0]                wbs_stb_i;
  logic [NUM_MASTERS-1:0]                wbs_we_i;
  logic [4*NUM_MASTERS-1:0]              wbs_sel_i;
  logic [BUS_ADDR_WIDTH*NUM_MASTERS-1:0] wbs_adr_i;
  logic [BUS_DATA_WIDTH*NUM_MASTERS-1:0] wbs_dat_i;
  logic [BUS_DATA_WIDTH*NUM_MASTERS-1:0] wbs_dat_o;
  logic [NUM_MASTERS-1:0]                wbs_ack_o;
  logic [NUM_MASTERS-1:0]                wbs_err_o;

  logic                      wbm_cyc_o;
  logic                      wbm_stb_o;
  logic                      wbm_we_o;
  logic [3:0]                wbm_sel_o;
  logic [BUS_ADDR_WIDTH-1:0] wbm_adr_o;
  logic [BUS_DATA_WIDTH-1:0] wbm_dat_o;
  logic [BUS_DATA_WIDTH-1:0] wbm_dat_i;
  logic                      wbm_ack_i;
  logic                      wbm_err_i;

  modport master (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );

endinterface

// File: rtl/wb_arb_rr_pick.sv
// Round-robin selector: finds the first set bit of the pending vector at or
// after rr_ptr, wrapping modulo NUM_MASTERS. Purely combinational.
//
// Ports:
//   pending : one bit per master slot holding a request
//   rr_ptr  : index where the search starts
//   pick    : index of the selected slot (0 when nothing is pending)
//   found   : high when any slot is pending
module wb_arb_rr_pick #(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0]         pending,
  input  logic [$clog2(NUM_MASTERS)-1:0] rr_ptr,
  output logic [$clog2(NUM_MASTERS)-1:0] pick,
  output logic                           found
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  logic [IDX_W-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest pending slot
  // (smallest offset from rr_ptr) is the one left in pick.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(rr_ptr) + k) % NUM_MASTERS);
      if (pending[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin Wishbone arbiter: each requesting master has a one-deep slot
// that captures a strobe (so one-cycle stb pulses are fine); the slots are
// served one at a time on a single shared Wishbone bus, and the slave reply
// is returned to the owning master as a one-cycle ack or err pulse.
//
// Ports:
//   wb_clk_i      : sole clock
//   wb_rst_i      : synchronous active-high reset
//   bus           : requester and shared-bus signals (wb_master_arbiter_if)
//   arb_grant_o   : one-hot owner while a transaction is issued/responded
//   arb_timeout_o : one-cycle pulse when the slave fails to answer in time
//
// Optional feature: define WB_ARB_TIMEOUT_EN to abort a silent slave after
// TIMEOUT_CYCLES clocks of ISSUE, returning an error with read data 0.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_master_arbiter_if.master    bus,
  output logic [NUM_MASTERS-1:0] arb_grant_o,
  output logic                   arb_timeout_o
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int DW    = BUS_DATA_WIDTH;
  localparam int AW    = BUS_ADDR_WIDTH;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 4 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("wb_master_arbiter: parameter out of legal range");
  end

  arb_state_t state, state_n;

  logic [NUM_MASTERS-1:0] pend, pend_n;
  logic [NUM_MASTERS-1:0] slot_we, slot_we_n;
  logic [3:0]             slot_sel [NUM_MASTERS];
  logic [3:0]             slot_sel_n [NUM_MASTERS];
  logic [AW-1:0]          slot_adr [NUM_MASTERS];
  logic [AW-1:0]          slot_adr_n [NUM_MASTERS];
  logic [DW-1:0]          slot_dat [NUM_MASTERS];
  logic [DW-1:0]          slot_dat_n [NUM_MASTERS];

  logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
  logic [IDX_W-1:0] gnt_idx, gnt_idx_n;
  logic [IDX_W-1:0] pick;
  logic             found;

  logic          cyc, cyc_n;
  logic          stb, stb_n;
  logic          we, we_n;
  logic [3:0]    sel, sel_n;
  logic [AW-1:0] adr, adr_n;
  logic [DW-1:0] dat, dat_n;

  logic [NUM_MASTERS-1:0] s_ack, s_ack_n;
  logic [NUM_MASTERS-1:0] s_err, s_err_n;
  logic [DW-1:0]          s_dat [NUM_MASTERS];
  logic [DW-1:0]          s_dat_n [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] grant, grant_n;

  logic [3:0]    req_sel [NUM_MASTERS];
  logic [AW-1:0] req_adr [NUM_MASTERS];
  logic [DW-1:0] req_dat [NUM_MASTERS];

`ifdef WB_ARB_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] tmo_cnt, tmo_cnt_n;
  logic [TMO_CNT_W:0]   tmo_next;
  logic                 tmo, tmo_n;
`endif

  // Split the flat per-master buses into per-slot views.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
    assign req_sel[gi]                  = bus.wbs_sel_i[4*gi +: 4];
    assign req_adr[gi]                  = bus.wbs_adr_i[AW*gi +: AW];
    assign req_dat[gi]                  = bus.wbs_dat_i[DW*gi +: DW];
    assign bus.wbs_dat_o[DW*gi +: DW]   = s_dat[gi];
  end

  wb_arb_rr_pick #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_pick (
    .pending(pend),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .found  (found)
  );

  // Next-state and next-output logic. Every output is a register, so this
  // block computes the value each register takes at the coming edge.
  always_comb begin
    state_n    = state;
    pend_n     = pend;
    slot_we_n  = slot_we;
    slot_sel_n = slot_sel;
    slot_adr_n = slot_adr;
    slot_dat_n = slot_dat;
    rr_ptr_n   = rr_ptr;
    gnt_idx_n  = gnt_idx;
    cyc_n      = cyc;
    stb_n      = stb;
    we_n       = we;
    sel_n      = sel;
    adr_n      = adr;
    dat_n      = dat;
    s_ack_n    = '0;
    s_err_n    = '0;
    s_dat_n    = s_dat;
    grant_n    = grant;
`ifdef WB_ARB_TIMEOUT_EN
    tmo_n      = 1'b0;
    tmo_cnt_n  = tmo_cnt;
    tmo_next   = {1'b0, tmo_cnt} + (TMO_CNT_W+1)'(1);
`endif

    // A strobe into an occupied slot is dropped, not queued.
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (bus.wbs_cyc_i[i] && bus.wbs_stb_i[i] && !pend[i]) begin
        pend_n[i]     = 1'b1;
        slot_we_n[i]  = bus.wbs_we_i[i];
        slot_sel_n[i] = req_sel[i];
        slot_adr_n[i] = req_adr[i];
        slot_dat_n[i] = req_dat[i];
      end
    end

    unique case (state)
      IDLE: begin
        if (found) begin
          gnt_idx_n      = pick;
          grant_n        = '0;
          grant_n[pick]  = 1'b1;
          cyc_n          = 1'b1;
          stb_n          = 1'b1;
          we_n           = slot_we[pick];
          sel_n          = slot_sel[pick];
          adr_n          = slot_adr[pick];
          dat_n          = slot_dat[pick];
          state_n        = ISSUE;
`ifdef WB_ARB_TIMEOUT_EN
          tmo_cnt_n      = '0;
`endif
        end
      end

      ISSUE: begin
        // A real slave reply always beats the timeout; err beats ack.
        if (bus.wbm_err_i || bus.wbm_ack_i) begin
          cyc_n            = 1'b0;
          stb_n            = 1'b0;
          s_dat_n[gnt_idx] = bus.wbm_dat_i;
          if (bus.wbm_err_i) begin
            s_err_n[gnt_idx] = 1'b1;
          end else begin
            s_ack_n[gnt_idx] = 1'b1;
          end
          state_n = RESP;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (tmo_next == (TMO_CNT_W+1)'(TIMEOUT_CYCLES)) begin
          cyc_n            = 1'b0;
          stb_n            = 1'b0;
          s_dat_n[gnt_idx] = '0;
          s_err_n[gnt_idx] = 1'b1;
          tmo_n            = 1'b1;
          state_n          = RESP;
        end else begin
          tmo_cnt_n = tmo_next[TMO_CNT_W-1:0];
        end
`endif
      end

      RESP: begin
        // The slot is released as the response pulse ends, so a master that
        // holds stb until it sees ack is not captured twice.
        pend_n[gnt_idx] = 1'b0;
        grant_n         = '0;
        rr_ptr_n        = (int'(gnt_idx) == NUM_MASTERS - 1) ? '0
                                                             : gnt_idx + IDX_W'(1);
        state_n         = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      pend     <= '0;
      slot_we  <= '0;
      slot_sel <= '{default: '0};
      slot_adr <= '{default: '0};
      slot_dat <= '{default: '0};
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      cyc      <= 1'b0;
      stb      <= 1'b0;
      we       <= 1'b0;
      sel      <= '0;
      adr      <= '0;
      dat      <= '0;
      s_ack    <= '0;
      s_err    <= '0;
      s_dat    <= '{default: '0};
      grant    <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      tmo_cnt  <= '0;
      tmo      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      pend     <= pend_n;
      slot_we  <= slot_we_n;
      slot_sel <= slot_sel_n;
      slot_adr <= slot_adr_n;
      slot_dat <= slot_dat_n;
      rr_ptr   <= rr_ptr_n;
      gnt_idx  <= gnt_idx_n;
      cyc      <= cyc_n;
      stb      <= stb_n;
      we       <= we_n;
      sel      <= sel_n;
      adr      <= adr_n;
      dat      <= dat_n;
      s_ack    <= s_ack_n;
      s_err    <= s_err_n;
      s_dat    <= s_dat_n;
      grant    <= grant_n;
`ifdef WB_ARB_TIMEOUT_EN
      tmo_cnt  <= tmo_cnt_n;
      tmo      <= tmo_n;
`endif
    end
  end

  assign bus.wbm_cyc_o = cyc;
  assign bus.wbm_stb_o = stb;
  assign bus.wbm_we_o  = we;
  assign bus.wbm_sel_o = sel;
  assign bus.wbm_adr_o = adr;
  assign bus.wbm_dat_o = dat;
  assign bus.wbs_ack_o = s_ack;
  assign bus.wbs_err_o = s_err;
  assign arb_grant_o   = grant;

`ifdef WB_ARB_TIMEOUT_EN
  assign arb_timeout_o = tmo;
`else
  assign arb_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed testbench for wb_master_arbiter with two masters and a short
// timeout limit. The shared slave is modelled by driving wbm_ack_i/err_i
// directly from the stimulus sequence.
module tb_wb_master_arbiter;

  logic       wb_clk_i;
  logic       wb_rst_i;
  logic [1:0] arb_grant_o;
  logic       arb_timeout_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int n;
  logic [1:0] seen;

  wb_master_arbiter_if #(
    .NUM_MASTERS   (2),
    .BUS_DATA_WIDTH(32),
    .BUS_ADDR_WIDTH(32)
  ) bus ();

  wb_master_arbiter #(
    .NUM_MASTERS   (2),
    .BUS_DATA_WIDTH(32),
    .BUS_ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .bus          (bus),
    .arb_grant_o  (arb_grant_o),
    .arb_timeout_o(arb_timeout_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Hard stop in case a bounded loop is ever broken.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before end of sequence");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Raise cyc/stb for master m with the given transfer attributes.
  task automatic applyStimulus(input int m, input logic [31:0] adr,
                               input logic we, input logic [31:0] dat);
    bus.wbs_cyc_i[m]          = 1'b1;
    bus.wbs_stb_i[m]          = 1'b1;
    bus.wbs_we_i[m]           = we;
    bus.wbs_sel_i[m*4 +: 4]   = 4'hF;
    bus.wbs_adr_i[m*32 +: 32] = adr;
    bus.wbs_dat_i[m*32 +: 32] = dat;
  endtask

  task automatic dropRequest(input int m);
    bus.wbs_cyc_i[m] = 1'b0;
    bus.wbs_stb_i[m] = 1'b0;
  endtask

  // Wait (bounded) for the shared bus cycle to start.
  task automatic waitIssue(input string tag);
    for (int i = 0; i < 20 && bus.wbm_cyc_o !== 1'b1; i++) tick();
    checkOutput(tag, 64'(bus.wbm_cyc_o), 64'd1);
  endtask

  // One clock of slave reply; afterwards the arbiter's response is visible.
  task automatic slaveReply(input logic ack, input logic err, input logic [31:0] dat);
    bus.wbm_ack_i = ack;
    bus.wbm_err_i = err;
    bus.wbm_dat_i = dat;
    tick();
    bus.wbm_ack_i = 1'b0;
    bus.wbm_err_i = 1'b0;
    bus.wbm_dat_i = '0;
  endtask

  initial begin
    bus.wbs_cyc_i = '0;
    bus.wbs_stb_i = '0;
    bus.wbs_we_i  = '0;
    bus.wbs_sel_i = '0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    bus.wbm_dat_i = '0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_err_i = 1'b0;
    wb_rst_i      = 1'b1;
    tick();
    tick();
    wb_rst_i = 1'b0;

    // Reset state
    checkOutput("rst_cyc",   64'(bus.wbm_cyc_o), 64'd0);
    checkOutput("rst_stb",   64'(bus.wbm_stb_o), 64'd0);
    checkOutput("rst_adr",   64'(bus.wbm_adr_o), 64'd0);
    checkOutput("rst_ack",   64'(bus.wbs_ack_o), 64'd0);
    checkOutput("rst_err",   64'(bus.wbs_err_o), 64'd0);
    checkOutput("rst_sdat",  64'(bus.wbs_dat_o), 64'd0);
    checkOutput("rst_grant", 64'(arb_grant_o),   64'd0);
    checkOutput("rst_tmo",   64'(arb_timeout_o), 64'd0);

    // Contention with rr_ptr=0: master 0 first, then master 1
    applyStimulus(0, 32'h100, 1'b0, 32'h0);
    applyStimulus(1, 32'h200, 1'b0, 32'h0);
    tick();
    dropRequest(0);
    dropRequest(1);
    waitIssue("c1_first_issue");
    checkOutput("c1_first_grant", 64'(arb_grant_o), 64'h1);
    checkOutput("c1_first_adr",   64'(bus.wbm_adr_o), 64'h100);
    slaveReply(1'b1, 1'b0, 32'h1111_1111);
    checkOutput("c1_first_ack",   64'(bus.wbs_ack_o), 64'h1);
    checkOutput("c1_first_dat",   64'(bus.wbs_dat_o[31:0]), 64'h1111_1111);
    waitIssue("c1_second_issue");
    checkOutput("c1_second_grant", 64'(arb_grant_o), 64'h2);
    checkOutput("c1_second_adr",   64'(bus.wbm_adr_o), 64'h200);
    slaveReply(1'b1, 1'b0, 32'h2222_2222);
    checkOutput("c1_second_ack",  64'(bus.wbs_ack_o), 64'h2);
    checkOutput("c1_second_dat",  64'(bus.wbs_dat_o[63:32]), 64'h2222_2222);
    tick();

    // Single one-cycle strobe from master 0 with exact latency
    applyStimulus(0, 32'h10, 1'b0, 32'h0);
    tick();
    dropRequest(0);
    checkOutput("sp_cyc_capture_edge", 64'(bus.wbm_cyc_o), 64'd0);
    tick();
    checkOutput("sp_cyc",   64'(bus.wbm_cyc_o), 64'd1);
    checkOutput("sp_stb",   64'(bus.wbm_stb_o), 64'd1);
    checkOutput("sp_adr",   64'(bus.wbm_adr_o), 64'h10);
    checkOutput("sp_we",    64'(bus.wbm_we_o),  64'd0);
    checkOutput("sp_sel",   64'(bus.wbm_sel_o), 64'hF);
    checkOutput("sp_grant", 64'(arb_grant_o),   64'h1);
    tick();
    tick();
    checkOutput("sp_cyc_held", 64'(bus.wbm_cyc_o), 64'd1);
    checkOutput("sp_ack_early", 64'(bus.wbs_ack_o), 64'd0);
    slaveReply(1'b1, 1'b0, 32'hCAFE_F00D);
    checkOutput("sp_ack",        64'(bus.wbs_ack_o), 64'h1);
    checkOutput("sp_dat",        64'(bus.wbs_dat_o[31:0]), 64'hCAFE_F00D);
    checkOutput("sp_cyc_drop",   64'(bus.wbm_cyc_o), 64'd0);
    checkOutput("sp_grant_resp", 64'(arb_grant_o),   64'h1);
    tick();
    checkOutput("sp_ack_pulse",  64'(bus.wbs_ack_o), 64'd0);
    checkOutput("sp_grant_idle", 64'(arb_grant_o),   64'd0);

    // Contention with rr_ptr=1: master 1 first, then master 0
    applyStimulus(0, 32'h300, 1'b0, 32'h0);
    applyStimulus(1, 32'h400, 1'b0, 32'h0);
    tick();
    dropRequest(0);
    dropRequest(1);
    waitIssue("c2_first_issue");
    checkOutput("c2_first_grant", 64'(arb_grant_o), 64'h2);
    checkOutput("c2_first_adr",   64'(bus.wbm_adr_o), 64'h400);
    slaveReply(1'b1, 1'b0, 32'h3333_3333);
    checkOutput("c2_first_ack",   64'(bus.wbs_ack_o), 64'h2);
    waitIssue("c2_second_issue");
    checkOutput("c2_second_grant", 64'(arb_grant_o), 64'h1);
    checkOutput("c2_second_adr",   64'(bus.wbm_adr_o), 64'h300);
    slaveReply(1'b1, 1'b0, 32'h4444_4444);
    checkOutput("c2_second_ack",  64'(bus.wbs_ack_o), 64'h1);
    tick();

    // Error and ack together: error wins
    applyStimulus(0, 32'h30, 1'b1, 32'hDEAD_BEEF);
    tick();
    dropRequest(0);
    waitIssue("er_issue");
    checkOutput("er_we",  64'(bus.wbm_we_o),  64'd1);
    checkOutput("er_dat", 64'(bus.wbm_dat_o), 64'hDEAD_BEEF);
    slaveReply(1'b1, 1'b1, 32'h55);
    checkOutput("er_err", 64'(bus.wbs_err_o), 64'h1);
    checkOutput("er_ack", 64'(bus.wbs_ack_o), 64'h0);
    tick();
    checkOutput("er_err_pulse", 64'(bus.wbs_err_o), 64'h0);

    // Second strobe into an occupied slot is dropped
    applyStimulus(1, 32'h20, 1'b0, 32'h0);
    tick();
    applyStimulus(1, 32'h24, 1'b0, 32'h0);
    tick();
    dropRequest(1);
    waitIssue("oc_issue");
    checkOutput("oc_adr",   64'(bus.wbm_adr_o), 64'h20);
    checkOutput("oc_grant", 64'(arb_grant_o),   64'h2);
    slaveReply(1'b1, 1'b0, 32'h6666_6666);
    checkOutput("oc_ack", 64'(bus.wbs_ack_o), 64'h2);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.wbm_cyc_o === 1'b1) n++;
    end
    checkOutput("oc_no_second", 64'(n), 64'd0);

    // Silent slave
    applyStimulus(0, 32'h40, 1'b0, 32'h0);
    tick();
    dropRequest(0);
    waitIssue("to_issue");
    bus.wbm_dat_i = 32'hFFFF_FFFF;
`ifdef WB_ARB_TIMEOUT_EN
    n = 0;
    while (bus.wbm_cyc_o === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    checkOutput("to_cyc_clocks", 64'(n), 64'd8);
    checkOutput("to_err",  64'(bus.wbs_err_o), 64'h1);
    checkOutput("to_ack",  64'(bus.wbs_ack_o), 64'h0);
    checkOutput("to_pulse", 64'(arb_timeout_o), 64'd1);
    checkOutput("to_dat",  64'(bus.wbs_dat_o[31:0]), 64'h0);
    tick();
    checkOutput("to_pulse_end", 64'(arb_timeout_o), 64'd0);
    checkOutput("to_err_end",   64'(bus.wbs_err_o), 64'h0);
    bus.wbm_dat_i = '0;
`else
    n    = 0;
    seen = '0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.wbm_cyc_o === 1'b1) n++;
      seen = seen | {arb_timeout_o, |bus.wbs_err_o};
      tick();
    end
    checkOutput("nt_cyc_clocks", 64'(n), 64'd1000);
    checkOutput("nt_no_tmo_err", 64'(seen), 64'd0);
    slaveReply(1'b1, 1'b0, 32'h7777_7777);
    checkOutput("nt_ack", 64'(bus.wbs_ack_o), 64'h1);
    checkOutput("nt_dat", 64'(bus.wbs_dat_o[31:0]), 64'h7777_7777);
    tick();
`endif

    // Reset while a transaction is in ISSUE
    applyStimulus(1, 32'h50, 1'b0, 32'h0);
    tick();
    dropRequest(1);
    waitIssue("rs_issue");
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    checkOutput("rs_cyc",   64'(bus.wbm_cyc_o), 64'd0);
    checkOutput("rs_grant", 64'(arb_grant_o),   64'd0);
    seen = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | {bus.wbm_cyc_o, |(bus.wbs_ack_o | bus.wbs_err_o)};
    end
    checkOutput("rs_discarded", 64'(seen), 64'd0);
    applyStimulus(0, 32'h60, 1'b0, 32'h0);
    tick();
    dropRequest(0);
    waitIssue("rs_fresh_issue");
    checkOutput("rs_fresh_grant", 64'(arb_grant_o), 64'h1);
    checkOutput("rs_fresh_adr",   64'(bus.wbm_adr_o), 64'h60);
    slaveReply(1'b1, 1'b0, 32'h0000_600D);
    checkOutput("rs_fresh_ack", 64'(bus.wbs_ack_o), 64'h1);
    checkOutput("rs_fresh_dat", 64'(bus.wbs_dat_o[31:0]), 64'h600D);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_master_arbiter.md
WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of requesting masters (legal 2..4).
REQ-002 SHALL have parameter BUS_DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter BUS_ADDR_WIDTH, default 32, address width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, slave response limit in clocks (legal 1..65535).
REQ-005 SHALL use one clock and a synchronous, active-high reset: wb_clk_i input 1 (sole clock); wb_rst_i input 1 (reset).
REQ-006 SHALL have the following requester ports, one slice per master, slice i at the i-th lowest bits:
- wbs_cyc_i input NUM_MASTERS: request cycle.
- wbs_stb_i input NUM_MASTERS: request strobe; may be a one-cycle pulse.
- wbs_we_i input NUM_MASTERS: write enable.
- wbs_sel_i input 4*NUM_MASTERS: byte selects.
- wbs_adr_i input BUS_ADDR_WIDTH*NUM_MASTERS: address.
- wbs_dat_i input BUS_DATA_WIDTH*NUM_MASTERS: write data.
- wbs_dat_o output BUS_DATA_WIDTH*NUM_MASTERS: read data, valid with ack.
- wbs_ack_o output NUM_MASTERS: one-cycle completion pulse.
- wbs_err_o output NUM_MASTERS: one-cycle error pulse.
REQ-007 SHALL have the following shared-bus ports:
- wbm_cyc_o, wbm_stb_o, wbm_we_o: output 1 each.
- wbm_sel_o output 4; wbm_adr_o output BUS_ADDR_WIDTH; wbm_dat_o output BUS_DATA_WIDTH.
- wbm_dat_i input BUS_DATA_WIDTH; wbm_ack_i input 1; wbm_err_i input 1.
REQ-008 SHALL have status ports: arb_grant_o output NUM_MASTERS (one-hot owner, 0 when idle); arb_timeout_o output 1 (one-cycle timeout pulse).

Function
REQ-009 SHALL capture a request into slot i (pending flag, we, sel, adr, dat) on any clock where wbs_cyc_i[i]&wbs_stb_i[i] is high and slot i is free.
REQ-010 SHALL ignore strobes to an occupied slot; a slot frees on the clock its ack/err pulse is driven.
REQ-011 SHALL run FSM IDLE -> ISSUE -> RESP -> IDLE, with all outputs registered.
REQ-012 IDLE: when any slot is pending, SHALL pick the first pending slot at or after rr_ptr (modulo NUM_MASTERS), load wbm_* from that slot, and enter ISSUE; wbm_cyc_o/stb_o rise the clock after the slot is seen pending.
REQ-013 ISSUE: SHALL hold wbm_cyc_o=wbm_stb_o=1 and a stable address/data until wbm_ack_i or wbm_err_i, then latch wbm_dat_i, drop cyc/stb next clock, and enter RESP.
REQ-014 RESP: SHALL pulse wbs_ack_o[g] (slave ack) or wbs_err_o[g] (slave err) for exactly one clock with wbs_dat_o slice g valid, clear pending[g], set rr_ptr=(g+1) mod NUM_MASTERS, and return to IDLE.
REQ-015 SHALL give wbm_err_i priority over wbm_ack_i when both are high.
REQ-016 arb_grant_o SHALL be one-hot of g in ISSUE and RESP, and 0 in IDLE.
REQ-017 Latency: capture at edge k gives wbm_stb_o high from edge k+2; slave ack at edge t gives wbs_ack_o at edge t+1.
REQ-018 A back-to-back request from a master whose ack has just been returned SHALL be re-capturable on the clock after its RESP.

Reset
REQ-019 On wb_rst_i=1 at a clock edge, SHALL set FSM=IDLE, all pending=0, rr_ptr=0, timeout counter=0, wbm_cyc_o/stb_o/we_o=0, wbm_sel_o/adr_o/dat_o=0, wbs_ack_o/err_o=0, wbs_dat_o=0, arb_grant_o=0, arb_timeout_o=0.
REQ-020 Reset during ISSUE SHALL drop wbm_cyc_o on the next clock and discard the in-flight transaction with no ack/err returned.

Configuration
REQ-021 With WB_ARB_TIMEOUT_EN defined, ISSUE SHALL count clocks from 0. If the count reaches TIMEOUT_CYCLES with no ack/err, it SHALL drop cyc/stb, go to RESP as an error with read data 0, and pulse arb_timeout_o. An ack/err on the expiry clock wins over the timeout.
REQ-022 Without WB_ARB_TIMEOUT_EN, ISSUE SHALL wait indefinitely, and arb_timeout_o SHALL be constant 0 with no counter logic.

Structure
REQ-023 Package wb_arb_pkg SHALL hold the FSM state type (IDLE, ISSUE, RESP), the state encoding, and the timeout counter width constant (16).
REQ-024 Sub-module wb_arb_rr_pick SHALL compute, combinationally, the first set bit of the pending vector at or after rr_ptr, plus a found flag.

Verification
REQ-025 Single pulse: master 0 pulses stb one clock, adr 0x10, read; slave acks 3 clocks after stb with 0xCAFEF00D -> wbs_ack_o[0] one clock, dat 0xCAFEF00D, arb_grant_o=01 during ISSUE.
REQ-026 Contention: masters 0 and 1 capture in the same clock with rr_ptr=0 -> master 0 served first, then master 1, and next simultaneous pair serves 1 then 0.
REQ-027 Error: slave asserts wbm_err_i and wbm_ack_i together -> wbs_err_o pulses, wbs_ack_o stays 0.
REQ-028 Timeout (macro on, TIMEOUT_CYCLES=8): slave silent -> cyc drops after 8 ISSUE clocks, wbs_err_o and arb_timeout_o pulse, dat 0. Macro off: cyc stays high 1000 clocks.
REQ-029 Reset mid-ISSUE: assert wb_rst_i one clock -> wbm_cyc_o=0 next clock, no ack/err, and a fresh request is then served normally from master 0.
REQ-030 Occupied slot: master 1 strobes again (adr 0x20) while its first request is pending -> only the first is issued and the second is dropped.
